// File: rtl/spi_fl_xip_sequencer.sv
// rtl/spi_fl_xip_sequencer.sv - word-read request sequencer with one-word hit buffer for the SPI flash core
//
// Purpose: turns single word-read requests into one flash read transaction
// on the SPI flash master core, and answers repeated reads of the buffered
// word directly from a one-word hit buffer.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     request handshake, req_addr is a byte address
//   resp_valid/ready    response handshake, resp_data/resp_err held until taken
//   invalidate          drops the hit buffer (flash contents changed)
//   fl_*  (out)         core command/address/start interface
//   fl_tready, fl_validflag_out, fl_data_out (in)  core status and read data
module spi_fl_xip_sequencer #(
  parameter int             ADDR_W    = 24,
  parameter int             DATA_W    = 32,
  parameter logic [7:0]     RD_CMD    = 8'h0B,
  parameter logic [3:0]     RD_DUMMY  = 4'd8,
  parameter logic [2:0]     RD_CT     = 3'd1,
  parameter int             TIMEOUT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic              invalidate,
  output logic [ADDR_W-1:0] fl_address,
  output logic [7:0]        fl_command,
  output logic [6:0]        fl_nmiso_bits,
  output logic [3:0]        fl_dummy_cycles,
  output logic [2:0]        fl_commtype,
  output logic              fl_validflag,
  input  logic              fl_tready,
  input  logic              fl_validflag_out,
  input  logic [DATA_W-1:0] fl_data_out
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

  localparam logic [TIMEOUT_W-1:0] TIMER_MAX = '1;

  state_t              state;
  logic [ADDR_W-1:0]   tag;
  logic [DATA_W-1:0]   buf_data;
  logic                buf_valid;
  logic [TIMEOUT_W-1:0] timer;
  logic                timed_out;
  logic [ADDR_W-1:0]   word_addr;

  // Masking (rather than slicing) keeps every req_addr bit in use.
  assign word_addr       = req_addr & ~ADDR_W'(3);

  assign fl_command      = RD_CMD;
  assign fl_nmiso_bits   = 7'(DATA_W);
  assign fl_dummy_cycles = RD_DUMMY;
  assign fl_commtype     = RD_CT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
      fl_validflag <= 1'b0;
      fl_address   <= '0;
      tag          <= '0;
      buf_data     <= '0;
      buf_valid    <= 1'b0;
      timer        <= '0;
      timed_out    <= 1'b0;
    end else begin
      fl_validflag <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            fl_address <= word_addr;
            timed_out  <= 1'b0;
            if (buf_valid && (tag == word_addr) && !invalidate) begin
              resp_data  <= buf_data;
              resp_err   <= 1'b0;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (fl_tready) begin
            fl_validflag <= 1'b1;
            timer        <= '0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A core completion in the same cycle as the limit still wins.
          if (fl_validflag_out) begin
            resp_data  <= fl_data_out;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            buf_data   <= fl_data_out;
            tag        <= fl_address;
            buf_valid  <= 1'b1;
            state      <= S_RESP;
          end else if (timer == TIMER_MAX) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            timed_out  <= 1'b1;
            state      <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (timed_out) begin
              // The core may still be busy with the abandoned read.
              state <= S_DRAIN;
            end else begin
              state     <= S_IDLE;
              req_ready <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (fl_tready) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
      // Placed last so it overrides a buffer fill in the same cycle.
      if (invalidate) buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_fl_xip_sequencer.sv
// tb/tb_spi_fl_xip_sequencer.sv - self-checking bench for spi_fl_xip_sequencer
module tb_spi_fl_xip_sequencer;

  localparam int TW   = 6;
  localparam int TMAX = (1 << TW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, invalidate;
  logic [23:0] req_addr, fl_address;
  logic [31:0] resp_data, fl_data_out;
  logic [7:0]  fl_command;
  logic [6:0]  fl_nmiso_bits;
  logic [3:0]  fl_dummy_cycles;
  logic [2:0]  fl_commtype;
  logic        fl_validflag, fl_tready, fl_validflag_out;

  int tests = 0;
  int fails = 0;

  // flash model / core responder state
  int pulse_cnt   = 0;
  int core_lat    = 1;
  bit core_silent = 1'b0;
  int inject_req  = 0;
  int inject_done = 0;

  always #5 clk = ~clk;

  spi_fl_xip_sequencer #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .invalidate(invalidate),
    .fl_address(fl_address), .fl_command(fl_command), .fl_nmiso_bits(fl_nmiso_bits),
    .fl_dummy_cycles(fl_dummy_cycles), .fl_commtype(fl_commtype),
    .fl_validflag(fl_validflag), .fl_tready(fl_tready),
    .fl_validflag_out(fl_validflag_out), .fl_data_out(fl_data_out)
  );

  function automatic logic [31:0] mem(input logic [23:0] wa);
    if (wa == 24'h000104) return 32'hDEADBEEF;
    return {wa[15:0] ^ 16'hA5C3, wa[23:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Core model: counts start pulses and answers each after core_lat cycles.
  initial begin
    int          cd;
    logic [23:0] la;
    cd = 0; la = '0;
    fl_validflag_out = 1'b0;
    fl_data_out      = '0;
    forever begin
      @(negedge clk);
      fl_validflag_out = 1'b0;
      if (rst) begin
        cd = 0;
      end else if (inject_req != inject_done) begin
        fl_validflag_out = 1'b1;
        fl_data_out      = 32'hBAD0_BAD0;
        inject_done      = inject_req;
      end else if (fl_validflag) begin
        pulse_cnt++;
        cd = core_silent ? 0 : core_lat;
        la = fl_address;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          fl_validflag_out = 1'b1;
          fl_data_out      = mem(la);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    check("req_ready_wait", {63'd0, req_ready}, 64'd1);
  endtask

  // Issues one request and waits for the response (not consumed).
  task automatic do_req(input logic [23:0] a, input int lat, input bit inv,
                        output bit hit, output int n);
    int p0;
    wait_ready();
    core_lat   = lat;
    p0         = pulse_cnt;
    req_addr   = a;
    req_valid  = 1'b1;
    invalidate = inv;
    @(negedge clk);
    req_valid  = 1'b0;
    invalidate = 1'b0;
    n = 1;
    while (!resp_valid && n < 2000) begin @(negedge clk); n++; end
    check("resp_wait", {63'd0, resp_valid}, 64'd1);
    hit = (pulse_cnt == p0);
    if (!hit) check("one_start_pulse", 64'(pulse_cnt - p0), 64'd1);
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic [23:0] addr;
    int          lat;
    bit          inv;
    bit          hit;
    logic [31:0] data;
    int          elat;
  } vec_t;

  vec_t        tbl[8];
  bit          hit;
  int          n;
  logic [23:0] a, wa, mtag;
  bit          mv, inv;
  int          lat;
  logic [31:0] hold;

  initial begin
    tbl[0] = '{24'h000104, 40, 1'b0, 1'b0, 32'hDEADBEEF, 43};
    tbl[1] = '{24'h000106,  5, 1'b0, 1'b1, 32'hDEADBEEF,  1};
    tbl[2] = '{24'h000107,  7, 1'b1, 1'b0, 32'hDEADBEEF, 10};
    tbl[3] = '{24'h000104,  5, 1'b0, 1'b1, 32'hDEADBEEF,  1};
    tbl[4] = '{24'h000200,  3, 1'b0, 1'b0, mem(24'h000200), 6};
    tbl[5] = '{24'h000104,  4, 1'b0, 1'b0, 32'hDEADBEEF,  7};
    tbl[6] = '{24'h000203,  9, 1'b0, 1'b0, mem(24'h000200), 12};
    tbl[7] = '{24'h000201,  2, 1'b0, 1'b1, mem(24'h000200), 1};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    invalidate = 1'b0; fl_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready",    {63'd0, req_ready},    64'd1);
    check("rst_resp_valid",   {63'd0, resp_valid},   64'd0);
    check("rst_resp_data",    64'(resp_data),        64'd0);
    check("rst_resp_err",     {63'd0, resp_err},     64'd0);
    check("rst_fl_validflag", {63'd0, fl_validflag}, 64'd0);
    check("rst_fl_address",   64'(fl_address),       64'd0);
    check("fl_command",       64'(fl_command),       64'h0B);
    check("fl_nmiso_bits",    64'(fl_nmiso_bits),    64'd32);
    check("fl_dummy_cycles",  64'(fl_dummy_cycles),  64'd8);
    check("fl_commtype",      64'(fl_commtype),      64'd1);
    rst = 1'b0;
    @(negedge clk);

    // table-driven hit/miss vectors
    for (int i = 0; i < 8; i++) begin
      do_req(tbl[i].addr, tbl[i].lat, tbl[i].inv, hit, n);
      check($sformatf("vec%0d_hit", i),  {63'd0, hit},       {63'd0, tbl[i].hit});
      check($sformatf("vec%0d_data", i), 64'(resp_data),     64'(tbl[i].data));
      check($sformatf("vec%0d_err", i),  {63'd0, resp_err},  64'd0);
      check($sformatf("vec%0d_lat", i),  64'(n),             64'(tbl[i].elat));
      check($sformatf("vec%0d_addr", i), 64'(fl_address),    64'(tbl[i].addr & 24'hFFFFFC));
      consume();
    end

    // standalone invalidate in IDLE forces a new read
    do_req(24'h000104, 2, 1'b0, hit, n); consume();
    invalidate = 1'b1; @(negedge clk); invalidate = 1'b0;
    do_req(24'h000104, 3, 1'b0, hit, n);
    check("inval_idle_miss", {63'd0, hit}, 64'd0);
    check("inval_idle_data", 64'(resp_data), 64'hDEADBEEF);
    consume();

    // invalidate exactly on the completion cycle
    wait_ready();
    core_lat = 8; req_addr = 24'h000600; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    repeat (8 + 1) @(negedge clk);
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    check("inval_done_valid", {63'd0, resp_valid}, 64'd1);
    check("inval_done_data",  64'(resp_data), 64'(mem(24'h000600)));
    consume();
    do_req(24'h000600, 2, 1'b0, hit, n);
    check("inval_done_next_miss", {63'd0, hit}, 64'd0);
    consume();

    // backpressure: response and data held, no new accept
    do_req(24'h000500, 6, 1'b0, hit, n);
    hold = resp_data;
    check("bp_data", 64'(hold), 64'(mem(24'h000500)));
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_addr = 24'h000700;
      @(negedge clk);
      check($sformatf("bp%0d_valid", i), {63'd0, resp_valid}, 64'd1);
      check($sformatf("bp%0d_hold", i),  64'(resp_data), 64'(hold));
      check($sformatf("bp%0d_ready", i), {63'd0, req_ready}, 64'd0);
    end
    req_valid = 1'b0;
    consume();

    // timeout, drain, late pulse ignored, buffer kept
    do_req(24'h000300, 4, 1'b0, hit, n); consume();
    core_silent = 1'b1;
    do_req(24'h000400, 4, 1'b0, hit, n);
    check("to_err",  {63'd0, resp_err}, 64'd1);
    check("to_data", 64'(resp_data), 64'd0);
    check("to_lat_in_window", {63'd0, (n >= TMAX + 2) && (n <= TMAX + 3)}, 64'd1);
    fl_tready = 1'b0;
    consume();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) inject_req++;
      @(negedge clk);
      check($sformatf("drain%0d_ready", i), {63'd0, req_ready}, 64'd0);
      check($sformatf("drain%0d_resp", i),  {63'd0, resp_valid}, 64'd0);
    end
    core_silent = 1'b0;
    fl_tready = 1'b1;
    repeat (2) @(negedge clk);
    check("drain_exit_ready", {63'd0, req_ready}, 64'd1);
    do_req(24'h000300, 4, 1'b0, hit, n);
    check("to_buffer_kept_hit", {63'd0, hit}, 64'd1);
    check("to_buffer_kept_data", 64'(resp_data), 64'(mem(24'h000300)));
    consume();

    // async reset while waiting for the core
    wait_ready();
    core_lat = 30; req_addr = 24'h000800; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_req_ready",  {63'd0, req_ready},    64'd1);
    check("arst_resp_valid", {63'd0, resp_valid},   64'd0);
    check("arst_validflag",  {63'd0, fl_validflag}, 64'd0);
    check("arst_address",    64'(fl_address),       64'd0);
    check("arst_resp_data",  64'(resp_data),        64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req(24'h000300, 3, 1'b0, hit, n);
    check("arst_next_miss", {63'd0, hit}, 64'd0);
    check("arst_next_data", 64'(resp_data), 64'(mem(24'h000300)));
    consume();

    // randomized requests against a one-word cache model
    mv = 1'b1; mtag = 24'h000300;
    for (int i = 0; i < 40; i++) begin
      a   = 24'h000A00 + 24'($urandom_range(0, 3)) * 24'h40 + 24'($urandom_range(0, 3));
      inv = ($urandom_range(0, 5) == 0);
      lat = $urandom_range(1, 20);
      wa  = a & 24'hFFFFFC;
      if (inv) mv = 1'b0;
      do_req(a, lat, inv, hit, n);
      check($sformatf("rnd%0d_hit", i),  {63'd0, hit}, {63'd0, mv && (mtag == wa)});
      check($sformatf("rnd%0d_data", i), 64'(resp_data), 64'(mem(wa)));
      check($sformatf("rnd%0d_lat", i),  64'(n), (mv && (mtag == wa)) ? 64'd1 : 64'(lat + 3));
      check($sformatf("rnd%0d_addr", i), 64'(fl_address), 64'(wa));
      mv = 1'b1; mtag = wa;
      consume();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
